// File: rtl/cla_pkg.sv
// rtl/cla_pkg.sv - shared state encoding and width default for the CLA accumulator
package cla_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int CLA_DEFAULT_SIZE = 8;

endpackage

// File: rtl/cla_adder.sv
// rtl/cla_adder.sv - carry-lookahead adder; each carry is a flat sum of generate/propagate products
module cla_adder #(
  parameter int ADDER_SIZE = 8
) (
  input  logic [ADDER_SIZE-1:0] a,
  input  logic [ADDER_SIZE-1:0] b,
  input  logic                  cin,
  output logic [ADDER_SIZE-1:0] sum,
  output logic                  cout
);

  logic [ADDER_SIZE-1:0] g;
  logic [ADDER_SIZE-1:0] p;
  logic [ADDER_SIZE:0]   c;
  logic                  pp;

  always_comb begin
    g    = a & b;
    p    = a ^ b;
    c    = '0;
    pp   = 1'b1;
    c[0] = cin;
    // c[i+1] = g[i] | p[i]g[i-1] | ... | p[i..0]cin, expanded without rippling
    for (int i = 0; i < ADDER_SIZE; i++) begin
      pp = 1'b1;
      for (int j = i; j >= 0; j--) begin
        c[i+1] = c[i+1] | (pp & g[j]);
        pp     = pp & p[j];
      end
      c[i+1] = c[i+1] | (pp & cin);
    end
    sum  = p ^ c[ADDER_SIZE-1:0];
    cout = c[ADDER_SIZE];
  end

endmodule

// File: rtl/cla_accumulator.sv
// rtl/cla_accumulator.sv - packet accumulator on a single CLA; CLA_ACC_SATURATE_EN selects saturation
module cla_accumulator
  import cla_pkg::*;
#(
  parameter int ADDER_SIZE = CLA_DEFAULT_SIZE
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [ADDER_SIZE-1:0] in_data,
  input  logic                  in_last,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ADDER_SIZE-1:0] out_sum,
  output logic                  out_ovf,
  output logic                  busy
);

  state_t                state;
  state_t                state_nx;
  logic [ADDER_SIZE-1:0] acc;
  logic [ADDER_SIZE-1:0] acc_nx;
  logic [ADDER_SIZE-1:0] add_a;
  logic [ADDER_SIZE-1:0] add_sum;
  logic                  add_cout;
  logic                  ovf;
  logic                  ovf_nx;
  logic                  ready_q;

  // Zeroing the accumulator operand in IDLE lets the same adder load the first beat.
  assign add_a = (state == IDLE) ? '0 : acc;

  cla_adder #(
    .ADDER_SIZE(ADDER_SIZE)
  ) u_adder (
    .a   (add_a),
    .b   (in_data),
    .cin (1'b0),
    .sum (add_sum),
    .cout(add_cout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      acc     <= '0;
      ovf     <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      state   <= state_nx;
      acc     <= acc_nx;
      ovf     <= ovf_nx;
      ready_q <= 1'b1;
    end
  end

  always_comb begin
    state_nx  = state;
    acc_nx    = acc;
    ovf_nx    = ovf;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_sum   = '0;
    out_ovf   = 1'b0;
    busy      = 1'b0;
    case (state)
      IDLE: begin
        in_ready = ready_q;
        if (in_valid && ready_q) begin
          acc_nx   = add_sum;
          ovf_nx   = 1'b0;
          state_nx = in_last ? DONE : ACCUM;
        end
      end
      ACCUM: begin
        busy     = 1'b1;
        in_ready = 1'b1;
        if (in_valid) begin
`ifdef CLA_ACC_SATURATE_EN
          acc_nx = (add_cout || ovf) ? '1 : add_sum;
`else
          acc_nx = add_sum;
`endif
          ovf_nx   = ovf | add_cout;
          state_nx = in_last ? DONE : ACCUM;
        end
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        out_sum   = acc;
        out_ovf   = ovf;
        if (out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_cla_accumulator.sv
// tb/tb_cla_accumulator.sv - scoreboard bench for cla_accumulator with directed packets
module tb_cla_accumulator;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       in_last;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_sum;
  logic       out_ovf;
  logic       busy;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [7:0] sum;
    logic       ovf;
  } exp_t;

  exp_t sb[$];

`ifdef CLA_ACC_SATURATE_EN
  localparam logic [7:0] SUM_200_100 = 8'd255;
  localparam logic [7:0] SUM_WRAP    = 8'd255;
`else
  localparam logic [7:0] SUM_200_100 = 8'd44;
  localparam logic [7:0] SUM_WRAP    = 8'd0;
`endif

  always #5 clk = ~clk;

  cla_accumulator #(.ADDER_SIZE(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_last  (in_last),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_sum  (out_sum),
    .out_ovf  (out_ovf),
    .busy     (busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [7:0] s, input logic o);
    exp_t e;
    e.sum = s;
    e.ovf = o;
    sb.push_back(e);
  endtask

  // Called at a negedge; returns at the negedge right after the accepting edge.
  task automatic send(input logic [7:0] d, input logic last, input int gap);
    int n;
    n        = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) check("in_ready_timeout", 32'd0, 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  always @(negedge clk) begin
    exp_t e;
    #2;
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_out", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        check("out_sum", 32'(out_sum), 32'(e.sum));
        check("out_ovf", 32'(out_ovf), 32'(e.ovf));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    #1 rst_n = 1'b0;
    #11;
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_sum", 32'(out_sum), 32'd0);
    check("rst_out_ovf", 32'(out_ovf), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 check("ready_before_clk", 32'(in_ready), 32'd0);
    @(negedge clk);
    check("ready_after_clk", 32'(in_ready), 32'd1);

    // four-beat packet, one-cycle out_valid
    push(8'd100, 1'b0);
    send(8'd10, 1'b0, 0);
    check("busy_accum", 32'(busy), 32'd1);
    send(8'd20, 1'b0, 0);
    send(8'd30, 1'b0, 0);
    send(8'd40, 1'b1, 0);
    check("p1_valid", 32'(out_valid), 32'd1);
    @(negedge clk);
    check("p1_valid_drop", 32'(out_valid), 32'd0);

    // single beat latency
    push(8'h7F, 1'b0);
    send(8'h7F, 1'b1, 0);
    check("lat_valid", 32'(out_valid), 32'd1);
    check("lat_in_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    check("lat_valid_drop", 32'(out_valid), 32'd0);

    // carry out: wrap or saturate
    push(SUM_200_100, 1'b1);
    send(8'd200, 1'b0, 0);
    send(8'd100, 1'b1, 0);
    @(negedge clk);

    // carry on an early beat, later beats must not clear ovf or leave saturation
    push(SUM_WRAP, 1'b1);
    send(8'd255, 1'b0, 0);
    send(8'd1, 1'b0, 0);
    send(8'd0, 1'b1, 0);
    @(negedge clk);

    // back-pressure in DONE with a pending beat
    out_ready = 1'b0;
    push(8'd110, 1'b0);
    send(8'd50, 1'b0, 0);
    send(8'd60, 1'b1, 0);
    in_valid = 1'b1;
    in_data  = 8'd99;
    in_last  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check("stall_valid", 32'(out_valid), 32'd1);
      check("stall_sum", 32'(out_sum), 32'd110);
      check("stall_in_ready", 32'(in_ready), 32'd0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
    check("post_hs_busy", 32'(busy), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("no_beat_consumed", 32'(out_valid | busy), 32'd0);
    end

    // reset mid-packet discards partial sum
    send(8'd5, 1'b0, 0);
    send(8'd6, 1'b0, 0);
    check("mid_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_in_ready", 32'(in_ready), 32'd0);
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_sum", 32'(out_sum), 32'd0);
    check("mid_rst_ovf", 32'(out_ovf), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    push(8'd7, 1'b0);
    send(8'd3, 1'b0, 0);
    send(8'd4, 1'b1, 0);
    @(negedge clk);

    // gaps between beats
    push(8'd6, 1'b0);
    send(8'd1, 1'b0, 3);
    check("gap_busy", 32'(busy), 32'd1);
    check("gap_valid", 32'(out_valid), 32'd0);
    send(8'd2, 1'b0, 3);
    send(8'd3, 1'b1, 0);
    @(negedge clk);

    repeat (3) @(negedge clk);
    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/cla_accumulator.md
CLA_ACCUMULATOR -- requirements
Module: cla_accumulator

Interface
REQ-001 SHALL have parameter: ADDER_SIZE, default 8, operand/accumulator width in bits (>=2).
REQ-002 SHALL have port: clk  input  1  single clock, all state on rising edge.
REQ-003 SHALL have port: rst_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have port: in_valid  input  1  operand beat present.
REQ-005 SHALL have port: in_ready  output  1  block can accept a beat.
REQ-006 SHALL have port: in_data  input  ADDER_SIZE  unsigned operand.
REQ-007 SHALL have port: in_last  input  1  final beat of the current packet; qualified by in_valid.
REQ-008 SHALL have port: out_valid  output  1  packet sum available.
REQ-009 SHALL have port: out_ready  input  1  consumer takes the sum.
REQ-010 SHALL have port: out_sum  output  ADDER_SIZE  accumulated packet sum.
REQ-011 SHALL have port: out_ovf  output  1  a carry-out occurred anywhere in the packet.
REQ-012 SHALL have port: busy  output  1  high in ACCUM or DONE.

Function
REQ-013 SHALL transfer a beat only on a cycle with in_valid=1 and in_ready=1, and transfer the sum only on a cycle with out_valid=1 and out_ready=1.
REQ-014 SHALL implement three states: IDLE, ACCUM, DONE.
REQ-015 In IDLE, SHALL drive in_ready=1 and, on an accepted beat, load acc=in_data and ovf=0, then go to DONE if in_last=1, else to ACCUM.
REQ-016 In ACCUM, SHALL drive in_ready=1 and, on an accepted beat, load acc=acc+in_data (cin=0) and set ovf|=cout, then go to DONE if in_last=1, else stay in ACCUM.
REQ-017 In ACCUM with in_valid=0, SHALL hold acc, ovf and state unchanged; gaps of any length are allowed.
REQ-018 In DONE, SHALL drive in_ready=0, out_valid=1, out_sum=acc, out_ovf=ovf, and hold all three stable until the out_ready handshake, then go to IDLE.
REQ-019 Outside DONE, SHALL drive out_valid=0; out_sum and out_ovf are don't-care but SHALL be 0.
REQ-020 SHALL have a latency of 1 cycle: out_valid rises on the edge that accepts the in_last beat.
REQ-021 In DONE with in_valid=1, SHALL NOT accept the beat in the same cycle as the out_ready handshake; there is no bypass, so the next packet starts in IDLE.
REQ-022 Without saturation, SHALL compute the sum modulo 2^ADDER_SIZE.

Reset
REQ-023 With rst_n=0, SHALL asynchronously force state=IDLE, acc=0, ovf=0, out_valid=0, out_sum=0, out_ovf=0, busy=0; in_ready SHALL be 0 while rst_n=0 and 1 from the first clock after release.
REQ-024 On reset mid-packet (ACCUM or DONE), SHALL discard the partial or unread result; there is no recovery.

Configuration
REQ-025 The macro CLA_ACC_SATURATE_EN SHALL select saturation.
- Defined: on any carry-out, acc becomes all-ones and stays all-ones for the rest of the packet; ovf=1.
- Undefined: wrap per REQ-022; ovf=1 still reported.

Structure
REQ-026 The shared package cla_pkg SHALL hold the state encoding (IDLE=2'd0, ACCUM=2'd1, DONE=2'd2) and the default width constant.
REQ-027 SHALL instantiate exactly one cla_adder sub-module (ADDER_SIZE passed through).
- Operands: acc (forced to 0 in IDLE) and in_data; cin=0.
- Its cout feeds ovf and the saturation logic.
- No other adder in the block.

Verification (ADDER_SIZE=8)
REQ-028 Beats 10, 20, 30, 40 (last on 40) with out_ready=1 -> out_sum=100, out_ovf=0, out_valid for 1 cycle.
REQ-029 Beats 200, 100 (last) -> out_sum=44, out_ovf=1; with CLA_ACC_SATURATE_EN -> out_sum=255, out_ovf=1.
REQ-030 Single beat 0x7F with in_last=1 from IDLE -> out_valid=1 on the next edge, out_sum=0x7F.
REQ-031 out_ready held 0 for 5 cycles in DONE with in_valid=1 -> out_sum stable, in_ready=0, no beat consumed.
REQ-032 rst_n pulsed low in ACCUM after beats 5, 6 -> all outputs reset immediately; next packet 3, 4 (last) -> out_sum=7, out_ovf=0.
REQ-033 Beats 1, 2, 3 with 3-cycle in_valid gaps between them -> out_sum=6, acc unchanged during the gaps.
